// File: rtl/ws2812_rx_if.sv
// Output bundle of the WS2812 receiver: captured colour plus
// frame/word status and one-cycle event pulses.
interface ws2812_rx_if;
    logic [23:0] color;
    logic        valid;
    logic        frame_done;
    logic [8:0]  word_count;
    logic        error;

    modport master (
        output color,
        output valid,
        output frame_done,
        output word_count,
        output error
    );

    modport slave (
        input color,
        input valid,
        input frame_done,
        input word_count,
        input error
    );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 line receiver: decodes pulse widths into LED words and
// captures the word for one selected LED index.
module ws2812_rx #(
    parameter int CLK_FRE      = 32_000_000,
    parameter int WS2812_NUM   = 0,
    parameter int WS2812_WIDTH = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din,
    ws2812_rx_if.master bus
);

    localparam int MHZ = CLK_FRE / 1_000_000;
    localparam logic [31:0] T_BIT   = 32'(MHZ * 625 / 1000);
    localparam logic [31:0] T_MIN   = 32'(MHZ * 2 / 10);
    localparam logic [31:0] T_MAX   = 32'(MHZ * 15 / 10);
    localparam logic [31:0] T_RESET = 32'(MHZ * 50);
    localparam logic [31:0] LAST    = 32'(WS2812_WIDTH - 1);
    localparam logic [31:0] SEL     = 32'(WS2812_NUM);

    typedef enum logic [1:0] {SYNC, READY, HIGH, LOW} state_t;

    state_t state, state_n;

    logic s1, ds;
    logic [31:0] low_cnt, low_n;
    logic [31:0] high_cnt, high_n;
    logic [31:0] bit_cnt, bit_n;
    logic [31:0] word_cnt, word_n;
    logic [WS2812_WIDTH-1:0] shift, shift_n, word;
    logic [23:0] color_q, color_n;
    logic [8:0]  wc_q, wc_n;
    logic        valid_q, valid_n;
    logic        done_q, done_n;
    logic        err_q, err_n;
    logic        dbit;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_comb begin
        state_n = state;
        low_n   = low_cnt;
        high_n  = high_cnt;
        bit_n   = bit_cnt;
        word_n  = word_cnt;
        shift_n = shift;
        color_n = color_q;
        wc_n    = wc_q;
        valid_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        dbit    = (high_cnt >= T_BIT);
        word    = shift;
        // current bit merged into the partial word at its arrival slot
        for (int i = 0; i < WS2812_WIDTH; i++) begin
            if (bit_cnt == 32'(i)) word[i] = dbit;
        end
        unique case (state)
            SYNC: begin
                if (ds) begin
                    low_n = '0;
                end else if (sat_inc(low_cnt) >= T_RESET) begin
                    low_n   = '0;
                    state_n = READY;
                end else begin
                    low_n = sat_inc(low_cnt);
                end
            end
            READY: begin
                if (ds) begin
                    bit_n   = '0;
                    word_n  = '0;
                    shift_n = '0;
                    high_n  = 32'd1;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (ds) begin
                    if (sat_inc(high_cnt) >= T_MAX) begin
                        err_n   = 1'b1;
                        low_n   = '0;
                        state_n = SYNC;
                    end else begin
                        high_n = sat_inc(high_cnt);
                    end
                end else if (high_cnt < T_MIN) begin
                    err_n   = 1'b1;
                    low_n   = '0;
                    state_n = SYNC;
                end else begin
                    low_n   = 32'd1;
                    state_n = LOW;
                    if (bit_cnt >= LAST) begin
                        bit_n   = '0;
                        shift_n = '0;
                        word_n  = sat_inc(word_cnt);
                        if (word_cnt == SEL) begin
                            color_n = 24'(word);
                            valid_n = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_cnt + 32'd1;
                        shift_n = word;
                    end
                end
            end
            LOW: begin
                if (ds) begin
                    high_n  = 32'd1;
                    state_n = HIGH;
                end else if (sat_inc(low_cnt) >= T_RESET) begin
                    done_n  = 1'b1;
                    err_n   = (bit_cnt != '0);
                    wc_n    = (word_cnt > 32'd511) ? 9'd511 : word_cnt[8:0];
                    low_n   = '0;
                    state_n = READY;
                end else begin
                    low_n = sat_inc(low_cnt);
                end
            end
            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= SYNC;
            s1       <= 1'b0;
            ds       <= 1'b0;
            low_cnt  <= '0;
            high_cnt <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shift    <= '0;
            color_q  <= '0;
            wc_q     <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            s1       <= din;
            ds       <= s1;
            low_cnt  <= low_n;
            high_cnt <= high_n;
            bit_cnt  <= bit_n;
            word_cnt <= word_n;
            shift    <= shift_n;
            color_q  <= color_n;
            wc_q     <= wc_n;
            valid_q  <= valid_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    assign bus.color      = color_q;
    assign bus.valid      = valid_q;
    assign bus.frame_done = done_q;
    assign bus.word_count = wc_q;
    assign bus.error      = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: two receivers (LED 0 and LED 1)
// share one randomized serial line checked against a frame model.
module tb_ws2812_rx;

    localparam int T_BIT = 20;
    localparam int T_MIN = 6;
    localparam int T_MAX = 48;
    localparam int GAP   = 1700;

    typedef enum int {EV_VALID, EV_DONE, EV_ERR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [23:0] color;
        int          wc;
        bit          err;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic din = 1'b0;

    ws2812_rx_if b0 ();
    ws2812_rx_if b1 ();

    ws2812_rx #(
        .CLK_FRE(32_000_000), .WS2812_NUM(0), .WS2812_WIDTH(24)
    ) dut0 (.clk(clk), .reset_n(reset_n), .din(din), .bus(b0));

    ws2812_rx #(
        .CLK_FRE(32_000_000), .WS2812_NUM(1), .WS2812_WIDTH(24)
    ) dut1 (.clk(clk), .reset_n(reset_n), .din(din), .bus(b1));

    always #5 clk = ~clk;

    ev_t exp0[$];
    ev_t exp1[$];
    int  hi_q[$];
    int  lo_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    bit  check_en = 0;
    bit  chk_rst = 0;
    bit  rst_done = 0;
    bit  chk_end = 0;
    bit  end_done = 0;

    function automatic ev_t mk(kind_t k, logic [23:0] c, int wc, bit e);
        ev_t r;
        r.kind = k;
        r.color = c;
        r.wc = wc;
        r.err = e;
        return r;
    endfunction

    // Expected events of the frame in hi_q: a word completes every 24
    // good pulses, a bad pulse width aborts the frame with an error.
    task automatic model_frame();
        int bits = 0;
        int words = 0;
        logic [23:0] w = '0;
        bit bad = 0;
        if (hi_q.size() == 0) return;
        foreach (hi_q[i]) begin
            if (hi_q[i] < T_MIN || hi_q[i] >= T_MAX) begin
                bad = 1;
                break;
            end
            if (hi_q[i] >= T_BIT) w[bits % 24] = 1'b1;
            bits++;
            if (bits % 24 == 0) begin
                if (words == 0) exp0.push_back(mk(EV_VALID, w, 0, 0));
                if (words == 1) exp1.push_back(mk(EV_VALID, w, 0, 0));
                words++;
                w = '0;
            end
        end
        if (bad) begin
            exp0.push_back(mk(EV_ERR, '0, 0, 1));
            exp1.push_back(mk(EV_ERR, '0, 0, 1));
        end else begin
            exp0.push_back(mk(EV_DONE, '0, (words > 511) ? 511 : words, (bits % 24) != 0));
            exp1.push_back(mk(EV_DONE, '0, (words > 511) ? 511 : words, (bits % 24) != 0));
        end
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic play(input int from, input int upto, input bit gap_last);
        for (int i = from; i < upto; i++) begin
            hold(1'b1, hi_q[i]);
            hold(1'b0, (gap_last && i == upto - 1) ? GAP : lo_q[i]);
        end
    endtask

    task automatic add_bit(input int h, input int l);
        hi_q.push_back(h);
        lo_q.push_back(l);
    endtask

    task automatic add_word(input logic [23:0] v, input bit rnd);
        for (int i = 0; i < 24; i++) begin
            if (rnd) begin
                add_bit(v[i] ? int'($urandom_range(47, 20)) : int'($urandom_range(19, 6)),
                        int'($urandom_range(25, 6)));
            end else begin
                add_bit(v[i] ? 28 : 12, v[i] ? 12 : 27);
            end
        end
    endtask

    task automatic run_frame();
        model_frame();
        play(0, hi_q.size(), 1'b1);
        hi_q.delete();
        lo_q.delete();
    endtask

    task automatic check_bus(input int id, input logic v, input logic fd,
                             input logic er, input logic [23:0] c,
                             input logic [8:0] wc);
        ev_t got;
        ev_t e;
        bit ok;
        if (!(v || fd || er)) return;
        got = mk(v ? EV_VALID : (fd ? EV_DONE : EV_ERR), c, int'(wc), er);
        vectors++;
        if ((id == 0) ? (exp0.size() == 0) : (exp1.size() == 0)) begin
            miscompares++;
            $display("FAIL dut%0d unexpected event: got kind=%0d color=%h wc=%0d err=%0b, required none",
                     id, got.kind, c, wc, er);
            return;
        end
        e = (id == 0) ? exp0.pop_front() : exp1.pop_front();
        ok = (got.kind == e.kind) && !(v && (fd || er));
        if (e.kind == EV_VALID) ok = ok && (got.color == e.color);
        if (e.kind == EV_DONE) ok = ok && (got.wc == e.wc) && (got.err == e.err);
        if (!ok) begin
            miscompares++;
            $display("FAIL dut%0d event: got kind=%0d color=%h wc=%0d err=%0b, required kind=%0d color=%h wc=%0d err=%0b",
                     id, got.kind, c, wc, er, e.kind, e.color, e.wc, e.err);
        end
    endtask

    task automatic chk_zero(input string name, input int act);
        vectors++;
        if (act != 0) begin
            miscompares++;
            $display("FAIL reset %s: got %0d, required 0", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (chk_rst && !rst_done) begin
            chk_zero("color0", int'(b0.color));
            chk_zero("wc0", int'(b0.word_count));
            chk_zero("valid0", int'(b0.valid));
            chk_zero("done0", int'(b0.frame_done));
            chk_zero("err0", int'(b0.error));
            chk_zero("color1", int'(b1.color));
            chk_zero("wc1", int'(b1.word_count));
            chk_zero("valid1", int'(b1.valid));
            chk_zero("done1", int'(b1.frame_done));
            chk_zero("err1", int'(b1.error));
            rst_done <= 1'b1;
        end
        if (check_en) begin
            check_bus(0, b0.valid, b0.frame_done, b0.error, b0.color, b0.word_count);
            check_bus(1, b1.valid, b1.frame_done, b1.error, b1.color, b1.word_count);
        end
        if (chk_end && !end_done) begin
            vectors++;
            if (exp0.size() != 0 || exp1.size() != 0) begin
                miscompares++;
                $display("FAIL pending events: got %0d/%0d still expected, required 0/0",
                         exp0.size(), exp1.size());
            end
            end_done <= 1'b1;
        end
    end

    initial begin
        int nw;
        int extra;
        int ek;
        reset_n = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        chk_rst = 1;
        check_en = 1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // idle line: SYNC must leave silently
        hold(1'b0, 2000);

        add_word(24'h00000F, 0);
        run_frame();

        add_word(24'hAAAAAA, 0);
        add_word(24'h123456, 0);
        run_frame();

        add_bit(19, 20);
        add_bit(20, 20);
        add_bit(6, 20);
        add_bit(47, 20);
        for (int i = 0; i < 20; i++) add_bit(int'($urandom_range(47, 6)), 15);
        run_frame();

        add_word(24'hC3C3C3, 0);
        add_bit(28, 12);
        add_bit(5, 0);
        run_frame();

        add_bit(12, 27);
        add_bit(48, 0);
        run_frame();

        add_word(24'h0F0F0F, 0);
        for (int i = 0; i < 6; i++) add_bit(28, 12);
        run_frame();

        // reset pulse at bit 10; rest of the line must be ignored
        add_word(24'h777777, 0);
        add_word(24'h999999, 0);
        play(0, 10, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        play(10, hi_q.size(), 1'b1);
        hi_q.delete();
        lo_q.delete();

        add_word(24'h5A5A5A, 0);
        run_frame();

        for (int f = 0; f < 8; f++) begin
            nw = int'($urandom_range(2, 0));
            extra = ($urandom_range(3, 0) == 0) ? int'($urandom_range(23, 1)) : 0;
            ek = int'($urandom_range(4, 0));
            for (int k = 0; k < nw; k++) add_word(24'($urandom), 1);
            for (int k = 0; k < extra; k++)
                add_bit(int'($urandom_range(47, 6)), int'($urandom_range(25, 6)));
            if (ek == 0) add_bit(int'($urandom_range(5, 1)), 0);
            if (ek == 1) add_bit(int'($urandom_range(60, 48)), 0);
            if (hi_q.size() == 0) add_word(24'($urandom), 1);
            run_frame();
        end

        hold(1'b0, 50);
        @(posedge clk);
        chk_end = 1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
